// File: rtl/alu_hazard_ctrl_if.sv
// Decode/EX boundary bundle for alu_hazard_ctrl.
//
// Handshake semantics: there is no ready signal. Decode presents an
// instruction by holding id_valid high; it is accepted on a rising edge
// whenever stall is low. While stall is high, decode must hold the same
// instruction (PC and IF/ID frozen) and present it again on the next cycle.
// flush discards whatever decode presents in that cycle as well as the EX
// entry. ex_valid marks a real instruction in EX; EX outputs are meaningful
// to downstream logic only while ex_valid is high.
//
// Signals (master = decode/front end, slave = controller):
//   id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wb, id_load,
//   id_alu_op             : decoded instruction fields
//   flush                 : branch taken, kill decode and EX
//   alu_flag              : ALU flags {N, C, Z} for the op currently in EX
//   int_save, int_restore : CCR shadow save / restore pulses
//   stall                 : hold PC and IF/ID (combinational)
//   ex_valid, ex_alu_op   : registered EX instruction
//   ex_fwd1, ex_fwd2      : operand select (00 RF, 01 EX/MEM, 10 MEM/WB)
//   ccr                   : architectural condition codes {N, C, Z}
interface alu_hazard_ctrl_if #(
  parameter int REG_AW = 3
);
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_use1;
  logic              id_use2;
  logic [REG_AW-1:0] id_dst;
  logic              id_wb;
  logic              id_load;
  logic [2:0]        id_alu_op;
  logic              flush;
  logic [2:0]        alu_flag;
  logic              int_save;
  logic              int_restore;
  logic              stall;
  logic              ex_valid;
  logic [2:0]        ex_alu_op;
  logic [1:0]        ex_fwd1;
  logic [1:0]        ex_fwd2;
  logic [2:0]        ccr;

  modport master (
    output id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wb,
           id_load, id_alu_op, flush, alu_flag, int_save, int_restore,
    input  stall, ex_valid, ex_alu_op, ex_fwd1, ex_fwd2, ccr
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wb,
           id_load, id_alu_op, flush, alu_flag, int_save, int_restore,
    output stall, ex_valid, ex_alu_op, ex_fwd1, ex_fwd2, ccr
  );
endinterface

// File: rtl/alu_hazard_ctrl.sv
// Issue and hazard controller for the execute stage.
//
// Tracks the two in-flight instructions ahead of decode (EX and MEM entries),
// registers the ALU opcode and operand-forwarding selects into EX, inserts a
// one-cycle bubble on a load-use hazard, and owns the 3-bit condition-code
// register with an interrupt shadow copy.
//
// Ports:
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : alu_hazard_ctrl_if.slave (decode inputs, EX outputs, ccr)
module alu_hazard_ctrl #(
  parameter int REG_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  alu_hazard_ctrl_if.slave   bus
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  // EX entry
  logic              ex_valid_q;
  logic [REG_AW-1:0] ex_dst_q;
  logic              ex_wb_q;
  logic              ex_load_q;
  logic [2:0]        ex_op_q;
  logic [1:0]        ex_fwd1_q;
  logic [1:0]        ex_fwd2_q;

  // MEM entry; dropped after one cycle when it reaches WB
  logic              mem_valid_q;
  logic [REG_AW-1:0] mem_dst_q;
  logic              mem_wb_q;

  logic [2:0]        ccr_q;
  logic [2:0]        shadow_q;

  logic              stall;
  logic              bubble;
  logic [1:0]        fwd1;
  logic [1:0]        fwd2;
  logic [2:0]        ccr_alu;

  // Load-use: a load in EX cannot forward its data yet, so a dependent
  // instruction must wait one cycle. flush overrides because the dependent
  // instruction is being killed anyway.
  always_comb begin
    stall = 1'b0;
    if (!bus.flush && bus.id_valid && ex_valid_q && ex_load_q && ex_wb_q) begin
      stall = (bus.id_use1 && (bus.id_src1 == ex_dst_q)) ||
              (bus.id_use2 && (bus.id_src2 == ex_dst_q));
    end
  end

  assign bubble = bus.flush || stall;

  // Forwarding selects. The EX entry is the younger producer and wins;
  // a load in EX is excluded because its data is not ready (that case
  // stalls instead), while a load in MEM forwards from MEM/WB.
  always_comb begin
    fwd1 = FWD_RF;
    if (bus.id_use1 && ex_valid_q && ex_wb_q && !ex_load_q &&
        (ex_dst_q == bus.id_src1)) begin
      fwd1 = FWD_EXM;
    end else if (bus.id_use1 && mem_valid_q && mem_wb_q &&
                 (mem_dst_q == bus.id_src1)) begin
      fwd1 = FWD_MWB;
    end
  end

  always_comb begin
    fwd2 = FWD_RF;
    if (bus.id_use2 && ex_valid_q && ex_wb_q && !ex_load_q &&
        (ex_dst_q == bus.id_src2)) begin
      fwd2 = FWD_EXM;
    end else if (bus.id_use2 && mem_valid_q && mem_wb_q &&
                 (mem_dst_q == bus.id_src2)) begin
      fwd2 = FWD_MWB;
    end
  end

  // CCR update from the op currently in EX. NOT leaves carry alone.
  always_comb begin
    ccr_alu = ccr_q;
    if (ex_valid_q) begin
      case (ex_op_q)
        OP_ADD:  ccr_alu = bus.alu_flag;
        OP_NOT:  ccr_alu = {bus.alu_flag[2], ccr_q[1], bus.alu_flag[0]};
        default: ccr_alu = ccr_q;
      endcase
    end
  end

  // Pipe advance
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_dst_q    <= '0;
      ex_wb_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_op_q     <= OP_NOP;
      ex_fwd1_q   <= FWD_RF;
      ex_fwd2_q   <= FWD_RF;
      mem_valid_q <= 1'b0;
      mem_dst_q   <= '0;
      mem_wb_q    <= 1'b0;
    end else begin
      mem_valid_q <= ex_valid_q;
      mem_dst_q   <= ex_dst_q;
      mem_wb_q    <= ex_wb_q;
      if (bubble) begin
        ex_valid_q <= 1'b0;
        ex_dst_q   <= '0;
        ex_wb_q    <= 1'b0;
        ex_load_q  <= 1'b0;
        ex_op_q    <= OP_NOP;
        ex_fwd1_q  <= FWD_RF;
        ex_fwd2_q  <= FWD_RF;
      end else begin
        ex_valid_q <= bus.id_valid;
        ex_dst_q   <= bus.id_dst;
        ex_wb_q    <= bus.id_wb;
        ex_load_q  <= bus.id_load;
        ex_op_q    <= bus.id_alu_op;
        ex_fwd1_q  <= fwd1;
        ex_fwd2_q  <= fwd2;
      end
    end
  end

  // CCR and shadow. Save samples the pre-update CCR, so save+restore in one
  // cycle swaps the two registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_q    <= '0;
      shadow_q <= '0;
    end else begin
      if (bus.int_restore) begin
        ccr_q <= shadow_q;
      end else begin
        ccr_q <= ccr_alu;
      end
      if (bus.int_save) begin
        shadow_q <= ccr_q;
      end
    end
  end

  assign bus.stall     = stall;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_alu_op = ex_op_q;
  assign bus.ex_fwd1   = ex_fwd1_q;
  assign bus.ex_fwd2   = ex_fwd2_q;
  assign bus.ccr       = ccr_q;

endmodule

// File: doc/alu_hazard_ctrl.md
# alu_hazard_ctrl

Issue and hazard controller for the execute stage. It sits between decode and the ALU. It tracks the destinations of the two in-flight instructions ahead of decode and registers the ALU opcode and operand-forwarding selects into EX. It detects load-use hazards and inserts a one-cycle bubble, and it owns the 3-bit condition-code register (CCR), including an interrupt shadow copy.

## Interface
- Parameters
  - `REG_AW`, default 3: register-address width (8 GPRs).
- Ports
  - `clk` in 1: system clock; all state updates on the rising edge.
  - `rst` in 1: synchronous, active-high reset.
  - `id_valid` in 1: decode holds a valid instruction.
  - `id_src1`, `id_src2` in `REG_AW`: source register addresses.
  - `id_use1`, `id_use2` in 1: the instruction reads src1 / src2.
  - `id_dst` in `REG_AW`: destination register.
  - `id_wb` in 1: the instruction writes `id_dst`.
  - `id_load` in 1: the instruction is a memory load.
  - `id_alu_op` in 3: ALU opcode.
    - 000 nop
    - 001 / 010 pass in1
    - 011 add
    - 100 not in2
  - `flush` in 1: branch taken; kill the decode and EX entries.
  - `alu_flag` in 3: ALU flags for the current EX op; bit 0 Z, bit 1 C, bit 2 N.
  - `int_save`, `int_restore` in 1: single-cycle CCR shadow save / restore.
  - `stall` out 1: hold the PC and the IF/ID register (combinational).
  - `ex_valid` out 1: EX holds a real instruction.
  - `ex_alu_op` out 3: registered opcode driving the ALU.
  - `ex_fwd1`, `ex_fwd2` out 2: operand select.
    - 00 register file
    - 01 EX/MEM result
    - 10 MEM/WB result
  - `ccr` out 3: architectural flags.

## Operation
- Internal pipe:
  - EX entry {valid, dst, wb, load, op}.
  - MEM entry {valid, dst, wb}.
  - The MEM entry is dropped after one cycle, when it reaches WB.
- Load-use hazard:
  - `stall` = `id_valid` & EX.valid & EX.load & EX.wb & ((`id_use1` & `id_src1`==EX.dst) | (`id_use2` & `id_src2`==EX.dst)).
  - `stall` is purely combinational.
  - `stall` is forced 0 when `flush` = 1.
- Advance rule, every cycle not in reset:
  - MEM <= EX.
  - EX <= bubble (valid 0, op 000, fwd 00) if `flush` or `stall`.
  - Otherwise EX <= decode fields, with valid = `id_valid`.
- Forwarding select for operand n, computed at decode and registered into `ex_fwdn`:
  - 01 if `id_usen` & EX.valid & EX.wb & !EX.load & EX.dst==`id_srcn`.
  - Otherwise 10 if `id_usen` & MEM.valid & MEM.wb & MEM.dst==`id_srcn`.
  - Otherwise 00.
  - EX (the younger instruction) wins when both match.
  - A load in MEM forwards via 10.
- Register 0 is not special; matching on r0 forwards normally.
- CCR update mask, applied when EX.valid = 1:
  - op 011 writes Z, C and N from `alu_flag`.
  - op 100 writes Z and N; C is held.
  - All other ops leave the CCR unchanged.
- Shadow register:
  - `int_save` copies the current `ccr` into the shadow.
  - `int_restore` loads `ccr` from the shadow.
  - Priority on `ccr`: `rst` > `int_restore` > ALU update.
  - `int_save` samples the pre-update CCR value.
- Reset values:
  - EX and MEM entries invalid.
  - `ex_valid` 0, `ex_alu_op` 000, `ex_fwd1` and `ex_fwd2` 00.
  - `ccr` 000, shadow 000.
  - `stall` 0, a consequence of EX being invalid.

## Timing
- Decode-to-EX latency is 1 cycle: `ex_*` outputs reflect the decode inputs sampled on the previous edge.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM, `stall` drops and the dependent instruction enters EX with fwd 10.
- A CCR update becomes visible on `ccr` one edge after the op is in EX.
- `flush` with `stall` in the same cycle: `flush` wins, and `stall` = 0.
- `rst` asserted mid-stream clears all entries on that edge; in-flight instructions are lost.
- `int_save` and `int_restore` in the same cycle:
  - `ccr` <= shadow (old value).
  - shadow <= old `ccr`, i.e. a swap.

## Test plan
- Reset check: hold `rst` 2 cycles with random inputs; all outputs are 0 and `ccr` = 000 after release.
- Back-to-back add forwarding: r1<=add (dst1, wb) then an instruction using src1=1 → second op in EX with `ex_fwd1`=01. An instruction two behind using src2=1 → `ex_fwd2`=10.
- Load-use: load dst=3, next instruction uses src1=3 → `stall`=1 for one cycle and `ex_valid`=0 (bubble). The instruction then issues with `ex_fwd1`=10 and `stall`=0.
- Flush: raise `flush` during a load-use stall → `stall`=0, EX is a bubble next cycle, and MEM still receives the load.
- CCR masking:
  - add with `alu_flag`=110 → `ccr`=110.
  - not with `alu_flag`=001 → `ccr`=011 (C held).
  - op 001 with `alu_flag`=111 → `ccr` unchanged.
- Interrupt shadow:
  - `ccr`=101, pulse `int_save`; add sets `ccr`=010; pulse `int_restore` → `ccr`=101.
  - `int_restore` in the same cycle as an add → `ccr` = shadow value; the add's flags are discarded.
